apb_wb_bridge_mc: RTL
=====================

Name: apb_wb_bridge_mc

Overview:
- APB-slave to multi-channel Wishbone-classic-master bridge for peripheral controllers such as the SD host and future Wishbone IP.
- The APB window starting at BASE is split into N_CH equal sub-windows of 2^WIN_AW bytes each. One single-beat Wishbone cycle is issued to the selected channel per APB access.
- Adds byte strobes, Wishbone error forwarding, a bus timeout and out-of-range decode errors, all reported on pslverr.

Parameters:
- BASE, 16'h8000, APB byte address of channel 0 window.
- N_CH, 2, number of Wishbone channels (1..8).
- WIN_AW, 8, log2 of window size in bytes per channel.
- W_DATA, 32, data width (32 or 64); W_STRB = W_DATA/8.
- WB_ADDR_UH, 16'h4000, constant driven on wb_adr_o[31:16].
- TIMEOUT, 255, max cycles waiting for ack/err (1..65535); counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  16  APB byte address
- pwdata  in  W_DATA  APB write data
- pstrb  in  W_STRB  APB write strobes
- prdata  out  W_DATA  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- wb_adr_o  out  32  {WB_ADDR_UH, window offset zero-extended}
- wb_dat_o  out  W_DATA  write data, shared by all channels
- wb_sel_o  out  W_STRB  byte select, shared
- wb_we_o  out  1  write enable, shared
- wb_cyc_o, wb_stb_o  out  N_CH each  per-channel cycle/strobe
- wb_dat_i  in  N_CH*W_DATA  read data; channel c occupies bits [c*W_DATA +: W_DATA]
- wb_ack_i, wb_err_i  in  N_CH each  per-channel ack/err
- err_cnt  out  8  saturating count of error completions

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Access trigger: psel && penable && !pready, evaluated in IDLE only. The !pready term prevents re-triggering in the completion cycle.
- Decode:
  - off = paddr - BASE, 16-bit unsigned.
  - ch = off >> WIN_AW.
  - Valid iff paddr >= BASE and ch < N_CH.
- State IDLE:
  - On a valid trigger: latch ch. Drive wb_adr_o low bits = off[WIN_AW-1:0]; wb_dat_o = pwdata; wb_we_o = pwrite.
  - wb_sel_o = pwrite ? pstrb : all ones. A write with pstrb = 0 is still issued.
  - Set wb_cyc_o[ch] = wb_stb_o[ch] = 1, clear the counter, go to WAIT.
  - On an invalid trigger: go to DONE with pslverr = 1, prdata = 0, no Wishbone activity.
- State WAIT:
  - Only bit ch of wb_ack_i / wb_err_i is observed; other channels are ignored.
  - ack: if read, prdata <= wb_dat_i slice ch; pslverr <= 0.
  - err: pslverr <= 1, prdata <= 0. If ack and err are both asserted in the same cycle, err wins.
  - No response: counter increments each cycle. On the cycle the counter equals TIMEOUT-1 and no ack/err is present, complete with pslverr = 1, prdata = 0.
  - On any completion: drop cyc/stb in the same clock edge, set pready = 1, go to DONE.
- State DONE:
  - pready is high for exactly one cycle. Next edge: pready <= 0, pslverr <= 0, go to IDLE.
  - prdata holds its value until the next completion.
- Latency:
  - Wishbone ack sampled at edge k gives pready = 1 after edge k.
  - A zero-wait slave (ack in the first WAIT cycle) gives an APB access phase of 3 cycles including the penable cycle.
  - Decode error: access phase of 2 cycles.
- err_cnt increments on every completion with pslverr = 1 and saturates at 255.
- Back-to-back APB transfers: supported. IDLE accepts a new access on the cycle after DONE.
- psel dropping mid-WAIT (protocol violation): the Wishbone cycle still completes or times out normally; pready still pulses.
- Reset asserted mid-operation: cyc/stb/pready clear asynchronously; no completion is generated.
- At most one wb_cyc_o bit is high at any time (one-hot or zero); the bench asserts this.

Test Plan:
- Write BASE+0x104, pwdata 0xDEADBEEF, pstrb 0xF; ch1 acks after 2 cycles -> wb_cyc_o = 2'b10, wb_adr_o = 0x40000004, wb_sel_o = 0xF, wb_we_o = 1; pready one cycle, pslverr = 0.
- Read BASE+0x010; ch0 returns 0x12345678 with ack in the first WAIT cycle -> prdata = 0x12345678; access phase 3 cycles; wb_sel_o = 0xF.
- Read 0x8200 with N_CH = 2 (out of range), then 0x7FFC (below BASE) -> each gives pslverr = 1, prdata = 0, no wb_cyc_o; err_cnt = 2.
- Write to ch0 with TIMEOUT = 4 and no ack -> cyc dropped and pready with pslverr = 1 exactly 4 cycles after cyc rose; err_cnt increments.
- ch1 asserts ack and err together; separately, ch0 asserts a stray ack while ch1 is active -> err wins (pslverr = 1); the stray ch0 ack is ignored.
- 300 forced error completions -> err_cnt saturates at 255; assert rst_n low during WAIT -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/apb_wb_bridge_mc.sv
// APB slave to multi-channel Wishbone-classic master bridge.
// The APB window at BASE is split into N_CH sub-windows of 2^WIN_AW bytes.
// Each APB access becomes one single-beat Wishbone cycle on the selected channel.
// Wishbone errors, bus timeouts and out-of-range decodes are reported on pslverr.
// Every error completion is counted in a saturating 8-bit counter.
module apb_wb_bridge_mc #(
  parameter logic [15:0] BASE       = 16'h8000,
  parameter int          N_CH       = 2,
  parameter int          WIN_AW     = 8,
  parameter int          W_DATA     = 32,
  parameter logic [15:0] WB_ADDR_UH = 16'h4000,
  parameter int          TIMEOUT    = 255,
  localparam int         W_STRB     = W_DATA / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [15:0]              paddr,
  input  logic [W_DATA-1:0]        pwdata,
  input  logic [W_STRB-1:0]        pstrb,
  output logic [W_DATA-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [31:0]              wb_adr_o,
  output logic [W_DATA-1:0]        wb_dat_o,
  output logic [W_STRB-1:0]        wb_sel_o,
  output logic                     wb_we_o,
  output logic [N_CH-1:0]          wb_cyc_o,
  output logic [N_CH-1:0]          wb_stb_o,
  input  logic [N_CH*W_DATA-1:0]   wb_dat_i,
  input  logic [N_CH-1:0]          wb_ack_i,
  input  logic [N_CH-1:0]          wb_err_i,
  output logic [7:0]               err_cnt
);

  localparam int          CHW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [15:0] WIN_MASK = 16'((33'd1 << WIN_AW) - 33'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [15:0]       off;
  logic [15:0]       ch_full;
  logic [15:0]       adr_lo;
  logic [CHW-1:0]    ch_dec;
  logic [CHW-1:0]    ch_q;
  logic [N_CH-1:0]   ch_onehot;
  logic              dec_valid;

  logic              sel_ack;
  logic              sel_err;
  logic [W_DATA-1:0] sel_rdata;

  logic [CW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic              trigger;

  logic              issue;
  logic              dec_err;
  logic              wb_ok;
  logic              wb_fail;
  logic              err_event;

  // The !pready term keeps the completion cycle from launching a second access.
  assign trigger = psel && penable && !pready;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  // Address decode: window offset, channel index and range check.
  always_comb begin
    off       = paddr - BASE;
    ch_full   = off >> WIN_AW;
    dec_valid = (paddr >= BASE) && (ch_full < 16'(N_CH));
    ch_dec    = ch_full[CHW-1:0];
    adr_lo    = off & WIN_MASK;
    ch_onehot = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_onehot[c] = (ch_dec == CHW'(c));
    end
  end

  // Pick ack/err/data of the latched channel only; other channels are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == CHW'(c)) begin
        sel_ack   = wb_ack_i[c];
        sel_err   = wb_err_i[c];
        sel_rdata = wb_dat_i[c*W_DATA +: W_DATA];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the one-cycle event strobes that drive the datapath.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    dec_err    = 1'b0;
    wb_ok      = 1'b0;
    wb_fail    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          if (dec_valid) begin
            issue      = 1'b1;
            next_state = ST_WAIT;
          end else begin
            dec_err    = 1'b1;
            next_state = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        // err beats a simultaneous ack; timeout only fires when nothing answered.
        if (sel_err || (tmo_hit && !sel_ack)) begin
          wb_fail    = 1'b1;
          next_state = ST_DONE;
        end else if (sel_ack) begin
          wb_ok      = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    err_event = dec_err || wb_fail;
  end

  // Timeout counter: cleared when a cycle is issued, counts silent WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (issue) begin
      tmo_cnt <= '0;
    end else if ((state == ST_WAIT) && !wb_ok && !wb_fail) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // Wishbone master side: launch on issue, drop cyc/stb on any completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= '0;
      wb_stb_o <= '0;
    end else if (issue) begin
      ch_q     <= ch_dec;
      wb_adr_o <= {WB_ADDR_UH, adr_lo};
      wb_dat_o <= pwdata;
      wb_sel_o <= pwrite ? pstrb : '1;
      wb_we_o  <= pwrite;
      wb_cyc_o <= ch_onehot;
      wb_stb_o <= ch_onehot;
    end else if (wb_ok || wb_fail) begin
      wb_cyc_o <= '0;
      wb_stb_o <= '0;
    end
  end

  // APB completion: pready/pslverr pulse for one cycle, prdata holds until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else if (dec_err || wb_fail) begin
      pready  <= 1'b1;
      pslverr <= 1'b1;
      prdata  <= '0;
    end else if (wb_ok) begin
      pready  <= 1'b1;
      pslverr <= 1'b0;
      if (!wb_we_o) begin
        prdata <= sel_rdata;
      end
    end else if (state == ST_DONE) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end
  end

  // Saturating count of completions reported with pslverr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
